// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption datapath: INIT, rounds 1-10 with Rcon,
// then a pipeline flush that ends with a one-cycle done pulse aligned to ciphertext valid.
module aes_round_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic [7:0] Rcon_out,
    output logic [3:0] round,
    output logic       load_sel,
    output logic       last_round,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRound,
        StFlush
    } state_e;

    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
    localparam logic [3:0] LastRound = 4'd10;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic [2:0] cnt_q, cnt_d;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                round_d = 4'd0;
                rcon_d  = 8'h00;
                if (start) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                state_d = StRound;
                round_d = 4'd1;
                rcon_d  = 8'h01;
            end
            StRound: begin
                if (round_q == LastRound) begin
                    // Clear Rcon on exit so 0x36 is visible in round 10 only.
                    state_d = StFlush;
                    round_d = 4'd0;
                    rcon_d  = 8'h00;
                    cnt_d   = FlushInit;
                end else begin
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                end
            end
            StFlush: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only, so reset drops them without waiting for an edge.
    always_comb begin
        ready      = (state_q == StIdle);
        busy       = (state_q != StIdle);
        load_sel   = (state_q == StInit);
        Rcon_out   = (state_q == StRound) ? rcon_q : 8'h00;
        round      = (state_q == StRound) ? round_q : 4'd0;
        last_round = (state_q == StRound) && (round_q == LastRound);
        done       = (state_q == StFlush) && (cnt_q == 3'd0);
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (FLUSH_CYCLES 2, 1, 4) checked every cycle against a
// position-since-start reference model, plus a vector table and directed corner sequences.
module tb_aes_round_ctrl;

    logic clock;
    logic reset_n;
    logic start;

    logic [2:0] ready_w, busy_w, load_w, last_w, done_w;
    logic [7:0] rcon_w [3];
    logic [3:0] round_w [3];

    aes_round_ctrl #(.FLUSH_CYCLES(2)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .ready(ready_w[0]), .busy(busy_w[0]),
        .Rcon_out(rcon_w[0]), .round(round_w[0]), .load_sel(load_w[0]),
        .last_round(last_w[0]), .done(done_w[0])
    );
    aes_round_ctrl #(.FLUSH_CYCLES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .ready(ready_w[1]), .busy(busy_w[1]),
        .Rcon_out(rcon_w[1]), .round(round_w[1]), .load_sel(load_w[1]),
        .last_round(last_w[1]), .done(done_w[1])
    );
    aes_round_ctrl #(.FLUSH_CYCLES(4)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .start(start), .ready(ready_w[2]), .busy(busy_w[2]),
        .Rcon_out(rcon_w[2]), .round(round_w[2]), .load_sel(load_w[2]),
        .last_round(last_w[2]), .done(done_w[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    int fc [3] = '{2, 1, 4};

    // Reference model: an operation is just "edges since the start edge".
    int m_act [3];
    int m_pos [3];

    int cyc       = 0;
    int done_cnt0 = 0;
    int r36_cnt0  = 0;

    typedef struct packed {
        logic       start;
        logic       ready;
        logic       load_sel;
        logic [3:0] round;
        logic [7:0] rcon;
        logic       last_round;
        logic       done;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic logic [16:0] model_vec(input int i);
        logic       act;
        int         p;
        logic [3:0] rnd;
        logic [7:0] rc;
        act = (m_act[i] != 0);
        p   = m_pos[i];
        rnd = 4'd0;
        rc  = 8'h00;
        if (act && p >= 1 && p <= 10) begin
            rnd = 4'(p);
            rc  = rcon_tab[p-1];
        end
        return {!act, act, act && p == 0, rnd, rc, act && p == 10, act && p == 10 + fc[i]};
    endfunction

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_dut%0d", i),
                32'({ready_w[i], busy_w[i], load_w[i], round_w[i], rcon_w[i], last_w[i],
                     done_w[i]}),
                32'(model_vec(i)));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0;
            m_pos[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            if (m_act[i] == 0) begin
                if (start) begin
                    m_act[i] = 1;
                    m_pos[i] = 0;
                end
            end else begin
                m_pos[i]++;
                if (m_pos[i] == 11 + fc[i]) m_act[i] = 0;
            end
        end
        #1;
        cyc++;
        if (done_w[0]) done_cnt0++;
        if (rcon_w[0] == 8'h36) r36_cnt0++;
        check_model();
    endtask

    int last_done;
    int n36;

    initial begin
        // Expected single-operation trace for FLUSH_CYCLES=2, one row per edge from the start edge.
        vecs[0] = '{start: 1'b1, ready: 1'b0, load_sel: 1'b1, round: 4'd0, rcon: 8'h00,
                    last_round: 1'b0, done: 1'b0};
        for (int n = 1; n <= 10; n++) begin
            vecs[n] = '{start: 1'b0, ready: 1'b0, load_sel: 1'b0, round: 4'(n),
                        rcon: rcon_tab[n-1], last_round: (n == 10), done: 1'b0};
        end
        vecs[11] = '{start: 1'b0, ready: 1'b0, load_sel: 1'b0, round: 4'd0, rcon: 8'h00,
                     last_round: 1'b0, done: 1'b0};
        vecs[12] = '{start: 1'b0, ready: 1'b0, load_sel: 1'b0, round: 4'd0, rcon: 8'h00,
                     last_round: 1'b0, done: 1'b1};
        vecs[13] = '{start: 1'b0, ready: 1'b1, load_sel: 1'b0, round: 4'd0, rcon: 8'h00,
                     last_round: 1'b0, done: 1'b0};
        vecs[14] = vecs[13];

        model_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        #7;
        check_model();
        #5 reset_n = 1'b1;

        // Reset then idle.
        done_cnt0 = 0;
        repeat (20) tick();
        chk("idle_ready", 32'(ready_w), 32'h7);
        chk("idle_no_done", 32'(done_cnt0), 32'd0);

        // Single operation from the vector table.
        for (int v = 0; v < 15; v++) begin
            start = vecs[v].start;
            tick();
            chk($sformatf("vec%0d", v),
                32'({busy_w[0], ready_w[0], load_w[0], round_w[0], rcon_w[0], last_w[0],
                     done_w[0]}),
                32'({!vecs[v].ready, vecs[v].ready, vecs[v].load_sel, vecs[v].round,
                     vecs[v].rcon, vecs[v].last_round, vecs[v].done}));
        end
        start = 1'b0;
        repeat (6) tick();

        // Back-to-back with start held high: done every 14 cycles, one 0x36 per operation.
        start     = 1'b1;
        last_done = -1;
        n36       = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rcon_w[0] == 8'h36) n36++;
            if (done_w[0]) begin
                if (last_done >= 0) chk("b2b_period", 32'(cyc - last_done), 32'd14);
                chk("b2b_one_36", 32'(n36), 32'd1);
                last_done = cyc;
                n36       = 0;
            end
        end
        start = 1'b0;
        repeat (20) tick();

        // Start while busy at round 5 is ignored.
        done_cnt0 = 0;
        r36_cnt0  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        chk("busy_start_round", 32'(round_w[0]), 32'd5);
        start = 1'b0;
        repeat (20) tick();
        chk("busy_start_one_done", 32'(done_cnt0), 32'd1);
        chk("busy_start_one_36", 32'(r36_cnt0), 32'd1);

        // Asynchronous reset at round 7, between edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("pre_reset_round", 32'(round_w[0]), 32'd7);
        done_cnt0 = 0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("async_rst_rcon", 32'(rcon_w[0]), 32'h00);
        chk("async_rst_ready", 32'(ready_w), 32'h7);
        #1 reset_n = 1'b1;
        repeat (15) tick();
        chk("reset_no_done", 32'(done_cnt0), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("post_reset_done", 32'(done_cnt0), 32'd1);

        // Randomized start traffic against the model.
        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath. It accepts a start request and then steps through the initial key-addition round and rounds 1–10. Each round it drives the round constant (Rcon) and round-control strobes to the key-expansion and round logic, including the end-of-round pipeline register. It then waits for that register's two-stage pipeline to settle and pulses `done` in the exact cycle the 128-bit ciphertext output becomes valid.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles from the edge after the Rcon=0x36 cycle to ciphertext valid. Legal range 1–7. The value 2 matches the end-of-round capture register plus its output register.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  encryption request; sampled only while `ready`=1.
- `ready`  out  1  high in IDLE only; the block accepts `start` this cycle.
- `busy`  out  1  equals NOT `ready`.
- `Rcon_out`  out  8  round constant for the current round; 0x00 when not in a round 1–10.
- `round`  out  4  current round number, 0–10; 0 outside INIT/ROUND.
- `load_sel`  out  1  high in INIT only; selects plaintext XOR key into the state register.
- `last_round`  out  1  high only in round 10; MixColumns bypass.
- `done`  out  1  one-cycle pulse; ciphertext output is valid this cycle.

## Operation
States: IDLE, INIT, ROUND, FLUSH. Encoding is free.

Transitions and outputs per state:
- IDLE: `ready`=1. `Rcon_out`=0x00, `round`=0, all strobes low. If `start`=1 at an edge, go to INIT.
- INIT: one cycle. `round`=0, `load_sel`=1, `Rcon_out`=0x00. Next state is ROUND, with `round`=1 and `Rcon_out`=0x01.
- ROUND: each edge increments `round` and sets `Rcon_out` to xtime(`Rcon_out`).
  - xtime(r) = {r[6:0],0} XOR (r[7] ? 0x1B : 0x00).
  - Sequence: 01,02,04,08,10,20,40,80,1B,36 for rounds 1–10.
  - `last_round`=1 when `round`=10. At the edge leaving round 10, go to FLUSH.
- FLUSH: a 3-bit down-counter is loaded with FLUSH_CYCLES−1 on entry. `done`=1 in the cycle the counter reads 0. The next edge returns to IDLE.

Rules:
- `Rcon_out`=0x36 in exactly one cycle per operation: round 10. It must never equal 0x36 in any other state, since downstream capture keys on that value.
- `start` outside IDLE is ignored; it is neither queued nor a restart.
- `start` held high continuously starts a new operation on every IDLE cycle. That gives back-to-back operations with one IDLE cycle between `done` and the next INIT.
- Reset mid-operation: all outputs take their reset values immediately (asynchronously). No `done` is produced for the aborted operation.
- Reset values: `ready`=1, `busy`=0, `Rcon_out`=0x00, `round`=0, `load_sel`=0, `last_round`=0, `done`=0. State is IDLE.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `start` to any output.

## Timing
Let edge k be the edge where `start`=1 is sampled in IDLE.
- After edge k: INIT (`load_sel`=1).
- After edge k+n, n=1..10: round n, with the Rcon value listed above.
- After edge k+10: `Rcon_out`=0x36, `last_round`=1. Downstream captures at edge k+11.
- After edge k+10+FLUSH_CYCLES: `done`=1 for one cycle. With the default this is edge k+12, aligned with the downstream output register update.
- After edge k+11+FLUSH_CYCLES: IDLE, `ready`=1.
- Throughput with the default: one block per 14 cycles.

## Test plan
- Reset then idle: deassert `reset_n`, hold `start`=0 for 20 cycles -> `ready`=1, `Rcon_out`=0x00, `done` never asserts.
- Single operation: 1-cycle `start` pulse -> `load_sel` high for 1 cycle; `Rcon_out` = 01,02,04,08,10,20,40,80,1B,36 on consecutive cycles with `round` 1–10; `last_round` high only with 0x36; `done` exactly 12 edges after the start edge; `ready` 13 edges after.
- Back-to-back: `start` held high for 40 cycles -> `done` every 14 cycles; exactly one 0x36 cycle per operation.
- Start while busy: pulse `start` again at round 5 -> ignored; one `done` only; `Rcon_out` sequence undisturbed.
- Mid-operation reset: assert `reset_n`=0 asynchronously at round 7, between edges -> outputs drop to reset values before the next edge; no `done`; a fresh `start` afterwards runs a full correct sequence.
- Parameter sweep: FLUSH_CYCLES=1 and 4 -> `done` at edges k+11 and k+14 respectively; Rcon sequence unchanged.
